// File: rtl/dnoc_rd_ctrl.sv
// dnoc read-request controller: drives the loop address generator,
// issues SRAM reads and streams returned data through a credit FIFO.
module dnoc_rd_ctrl #(
  parameter int DATA_W     = 128,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_start,
  input  logic [CNT_W-1:0]  cfg_total,
  output logic              busy,
  output logic              done,
  output logic              mu_init_en,
  output logic              mu_valid,
  input  logic [12:0]       mu_addr,
  output logic              rd_req_vld,
  input  logic              rd_req_rdy,
  output logic [12:0]       rd_req_addr,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int OW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_INIT,
    S_ISSUE,
    S_DRAIN
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [CNT_W-1:0]  r_total;
  logic [CNT_W-1:0]  r_issued;
  logic [CNT_W-1:0]  r_returned;
  logic              r_inflight;
  logic              r_done;

  logic [DATA_W-1:0]     r_mem_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] r_mem_last;
  logic [AW-1:0]         r_wp;
  logic [AW-1:0]         r_rp;
  logic [OW-1:0]         r_cnt;

  logic          w_accept;
  logic          w_empty;
  logic [OW-1:0] w_occ;
  logic          w_credit;
  logic          w_hs;
  logic          w_push;
  logic          w_pop;
  logic          w_last_iss;
  logic          w_drained;

  assign w_accept   = cfg_start && (r_state == S_IDLE);
  assign w_empty    = (r_cnt == '0);
  // a request accepted last cycle already owns a FIFO slot
  assign w_occ      = r_cnt + OW'(r_inflight);
  assign w_credit   = (w_occ < OW'(FIFO_DEPTH));
  assign w_hs       = rd_req_vld && rd_req_rdy;
  assign w_push     = r_inflight;
  assign w_pop      = out_vld && out_rdy;
  assign w_last_iss = (r_issued == r_total - CNT_W'(1));
  assign w_drained  = !r_inflight &&
                      (w_empty || ((r_cnt == OW'(1)) && w_pop));

  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  assign mu_init_en  = (r_state == S_INIT);
  assign rd_req_vld  = (r_state == S_ISSUE) && w_credit;
  assign mu_valid    = w_hs;
  assign rd_req_addr = mu_addr;
  assign out_vld     = !w_empty;
  assign out_data    = r_mem_data[r_rp];
  assign out_last    = !w_empty && r_mem_last[r_rp];

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept && (cfg_total != '0)) w_next = S_INIT;
      S_INIT:  w_next = S_ISSUE;
      S_ISSUE: if (w_hs && w_last_iss) w_next = S_DRAIN;
      S_DRAIN: if (w_drained) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= (w_accept && (cfg_total == '0)) ||
                 ((r_state == S_DRAIN) && w_drained);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_total    <= '0;
      r_issued   <= '0;
      r_returned <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_hs;
      if (w_accept) r_total <= cfg_total;
      if (r_state == S_INIT) begin
        r_issued   <= '0;
        r_returned <= '0;
      end else begin
        if (w_hs)   r_issued   <= r_issued + CNT_W'(1);
        if (w_push) r_returned <= r_returned + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop)  r_rp <= r_rp + AW'(1);
      if (w_push && !w_pop)      r_cnt <= r_cnt + OW'(1);
      else if (!w_push && w_pop) r_cnt <= r_cnt - OW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wp] <= sram_rdata;
      r_mem_last[r_wp] <= (r_returned == r_total - CNT_W'(1));
    end
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(w_push && (r_cnt == OW'(FIFO_DEPTH)))
  );

endmodule

// File: tb/tb_dnoc_rd_ctrl.sv
// Scoreboard bench for dnoc_rd_ctrl with address-generator and SRAM models.
module tb_dnoc_rd_ctrl;
  localparam int DW = 128;
  localparam int FD = 4;
  localparam int CW = 16;

  typedef struct {
    logic          last;
    logic [DW-1:0] data;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_start = 1'b0;
  logic [CW-1:0] cfg_total = '0;
  logic          busy, done, mu_init_en, mu_valid;
  logic [12:0]   mu_addr = '0;
  logic          rd_req_vld;
  logic          rd_req_rdy = 1'b0;
  logic [12:0]   rd_req_addr;
  logic [DW-1:0] sram_rdata = '0;
  logic          out_vld;
  logic          out_rdy = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_last;

  dnoc_rd_ctrl #(.DATA_W(DW), .FIFO_DEPTH(FD), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_start(cfg_start), .cfg_total(cfg_total),
    .busy(busy), .done(done),
    .mu_init_en(mu_init_en), .mu_valid(mu_valid), .mu_addr(mu_addr),
    .rd_req_vld(rd_req_vld), .rd_req_rdy(rd_req_rdy),
    .rd_req_addr(rd_req_addr), .sram_rdata(sram_rdata),
    .out_vld(out_vld), .out_rdy(out_rdy),
    .out_data(out_data), .out_last(out_last)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] data_of(input logic [12:0] a,
                                            input logic [31:0] s);
    logic [31:0] w;
    w = ({19'h0, a} * 32'h9E3779B1) ^ s;
    return {w, ~w, w + 32'd1, {19'h0, a}};
  endfunction

  // address generator and SRAM models
  logic [12:0] base_g = '0;
  logic [12:0] step_g = '0;
  logic [31:0] salt = '0;

  always @(posedge clk) begin
    if (mu_init_en) mu_addr <= base_g;
    else if (mu_valid) mu_addr <= mu_addr + step_g;
  end

  always @(posedge clk)
    if (rd_req_vld && rd_req_rdy)
      sram_rdata <= data_of(rd_req_addr, salt);

  // ready drivers: 0 always 1, 1 toggle, 2 random, 3 held 0
  int rq_mode = 0;
  int or_mode = 0;
  always @(posedge clk) begin
    #1;
    case (rq_mode)
      0: rd_req_rdy = 1'b1;
      1: rd_req_rdy = ~rd_req_rdy;
      2: rd_req_rdy = 1'($urandom % 2);
      default: rd_req_rdy = 1'b0;
    endcase
    case (or_mode)
      0: out_rdy = 1'b1;
      2: out_rdy = ($urandom_range(0, 3) != 0);
      default: out_rdy = 1'b0;
    endcase
  end

  logic [12:0] exp_addr[$];
  beat_t       exp_beat[$];
  int hs_job = 0, pop_job = 0, first_hs = 0, last_hs = 0;
  int init_cnt = 0, done_cnt = 0, exp_init = 0, exp_done = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (mu_init_en) init_cnt++;
      if (done) done_cnt++;
      if (rd_req_vld && rd_req_rdy) begin
        hs_job++;
        if (hs_job == 1) first_hs = cyc;
        last_hs = cyc;
        if (exp_addr.size() == 0) begin
          chk("req_extra", {115'h0, rd_req_addr}, '1);
        end else begin
          logic [12:0] a;
          a = exp_addr.pop_front();
          chk("req_addr", {115'h0, rd_req_addr}, {115'h0, a});
        end
        chk("mu_valid_on_hs", {127'h0, mu_valid}, 1);
        chk("credit", {127'h0, (hs_job - pop_job) <= FD}, 1);
      end else if (mu_valid) begin
        chk("mu_valid_spurious", {127'h0, mu_valid}, 0);
      end
      if (out_vld && out_rdy) begin
        pop_job++;
        if (exp_beat.size() == 0) begin
          chk("beat_extra", out_data, '1);
        end else begin
          beat_t e;
          e = exp_beat.pop_front();
          chk("beat_data", out_data, e.data);
          chk("beat_last", {127'h0, out_last}, {127'h0, e.last});
        end
      end
    end
  end

  int st_cyc = 0;

  task automatic pulse_start(input int t);
    @(posedge clk); #1;
    cfg_total = CW'(t);
    cfg_start = 1'b1;
    st_cyc = cyc;
    @(posedge clk); #1;
    cfg_start = 1'b0;
  endtask

  task automatic start_job(input logic [12:0] b, input logic [12:0] s,
                           input int t);
    logic [12:0] a;
    beat_t bt;
    base_g = b;
    step_g = s;
    salt = $urandom;
    hs_job = 0;
    pop_job = 0;
    for (int k = 0; k < t; k++) begin
      a = b + 13'(k) * s;
      exp_addr.push_back(a);
      bt.last = (k == t - 1);
      bt.data = data_of(a, salt);
      exp_beat.push_back(bt);
    end
    exp_done++;
    if (t != 0) exp_init++;
    pulse_start(t);
  endtask

  task automatic wait_done(input int maxc, output int dcyc,
                           output logic bsy);
    dcyc = -1;
    bsy = 1'b1;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (done) begin
        dcyc = cyc;
        bsy = busy;
        return;
      end
    end
    chk("done_timeout", 0, 1);
  endtask

  task automatic chk_empty(input string nm);
    chk({nm, "_addr_q"}, exp_addr.size(), 0);
    chk({nm, "_beat_q"}, exp_beat.size(), 0);
  endtask

  task automatic chk_reset_outs(input string nm);
    chk(nm, {121'h0, busy, done, mu_init_en, mu_valid,
             rd_req_vld, out_vld, out_last}, 0);
  endtask

  initial begin
    int d;
    logic bsy;
    int ib;
    int n;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outs("reset_outs");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // single read, latency of done
    start_job(13'h010, 13'h1, 1);
    wait_done(50, d, bsy);
    chk("t1_done_lat", d - st_cyc, 5);
    chk("t1_busy_at_done", {127'h0, bsy}, 0);
    chk("t1_hs", hs_job, 1);
    chk_empty("t1");

    // 8 back-to-back requests, stride 2
    start_job(13'h000, 13'h2, 8);
    wait_done(100, d, bsy);
    chk("t2_b2b", last_hs - first_hs, 7);
    chk("t2_hs", hs_job, 8);
    chk_empty("t2");

    // output stalled: credit caps requests at FIFO depth
    or_mode = 3;
    start_job(13'h123, 13'h1, 10);
    repeat (30) @(negedge clk);
    chk("t3_capped", hs_job, FD);
    chk("t3_req_off", {127'h0, rd_req_vld}, 0);
    or_mode = 0;
    wait_done(100, d, bsy);
    chk_empty("t3");

    // toggling request ready, plus a start while busy
    rq_mode = 1;
    start_job(13'h100, 13'h3, 6);
    repeat (3) @(posedge clk);
    pulse_start(3);
    wait_done(100, d, bsy);
    chk("t4_hs", hs_job, 6);
    chk_empty("t4");
    rq_mode = 0;

    // zero-length job
    ib = init_cnt;
    exp_done++;
    pulse_start(0);
    @(negedge clk);
    chk("t5_done", {127'h0, done}, 1);
    chk("t5_busy", {127'h0, busy}, 0);
    @(negedge clk);
    chk("t5_done_once", {127'h0, done}, 0);
    chk("t5_no_init", init_cnt, ib);

    // reset mid-issue with 2 beats buffered
    or_mode = 3;
    start_job(13'h040, 13'h1, 10);
    n = 0;
    while (hs_job < 2 && n < 50) begin
      @(posedge clk); #2;
      n++;
    end
    rq_mode = 3;
    rd_req_rdy = 1'b0;
    chk("t6_two_hs", hs_job, 2);
    repeat (3) @(negedge clk);
    chk("t6_buffered", {127'h0, out_vld}, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk_reset_outs("t6_reset_outs");
    exp_addr.delete();
    exp_beat.delete();
    exp_done--;
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    rq_mode = 0;
    or_mode = 0;
    start_job(13'h200, 13'h5, 5);
    wait_done(100, d, bsy);
    chk("t6_after_hs", hs_job, 5);
    chk_empty("t6");

    // randomized jobs
    rq_mode = 2;
    or_mode = 2;
    for (int j = 0; j < 12; j++) begin
      start_job(13'($urandom), 13'($urandom_range(0, 7)),
                $urandom_range(1, 20));
      wait_done(600, d, bsy);
      chk("rnd_busy_at_done", {127'h0, bsy}, 0);
      chk_empty("rnd");
    end

    repeat (3) @(negedge clk);
    chk("init_count", init_cnt, exp_init);
    chk("done_count", done_cnt, exp_done);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
